// File: rtl/ahb_decoder.sv
// ahb_decoder: AHB-Lite address decoder and data-phase select generator for a
// 4-slave interconnect, with an optional error-returning default slave.
//
// Build option: define DEFAULT_SLAVE_EN to include the default slave.
//   - Without it, unmapped addresses fall through to slave 4.
//   - Without it, def_sel / hreadyout_def / hresp_def are tied to their idle values.
//
// Ports:
//   hclk, hresetn      bus clock, asynchronous active-low reset
//   haddr[31:0]        master address (address phase)
//   htrans[1:0]        transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//   hready             final bus hready as seen by the master
//   hsel_1..hsel_4     combinational one-hot slave selects (address phase)
//   sel[1:0]           registered data-phase index for the response mux
//   def_sel            data phase currently owned by the default slave
//   hreadyout_def      default-slave hreadyout
//   hresp_def          default-slave hresp (1 = ERROR)
module ahb_decoder #(
  parameter logic [3:0] SLV1_REGION = 4'h0,
  parameter logic [3:0] SLV2_REGION = 4'h1,
  parameter logic [3:0] SLV3_REGION = 4'h2,
  parameter logic [3:0] SLV4_REGION = 4'h3
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hready,
  output logic        hsel_1,
  output logic        hsel_2,
  output logic        hsel_3,
  output logic        hsel_4,
  output logic [1:0]  sel,
  output logic        def_sel,
  output logic        hreadyout_def,
  output logic        hresp_def
);

  localparam int unsigned REGION_W = 4;
  localparam int unsigned IDX_W    = 2;

  logic [REGION_W-1:0] region_c;
  logic                m1_c, m2_c, m3_c, m4_c;
  logic                unmapped_c;
  logic [IDX_W-1:0]    idx_c;

  // Address bits below the region field and htrans[0] do not affect decode.
  logic unused_ok;
  assign unused_ok = ^{haddr[27:0], htrans};

  // Region compare with lowest-index priority.
  always_comb begin
    region_c   = haddr[31:28];
    m1_c       = (region_c == SLV1_REGION);
    m2_c       = (region_c == SLV2_REGION) & ~m1_c;
    m3_c       = (region_c == SLV3_REGION) & ~m1_c & ~m2_c;
    m4_c       = (region_c == SLV4_REGION) & ~m1_c & ~m2_c & ~m3_c;
    unmapped_c = ~(m1_c | m2_c | m3_c | m4_c);
  end

  // Select outputs and data-phase index; unmapped either goes nowhere or to slave 4.
  always_comb begin
    hsel_1 = m1_c;
    hsel_2 = m2_c;
    hsel_3 = m3_c;
`ifdef DEFAULT_SLAVE_EN
    hsel_4 = m4_c;
`else
    hsel_4 = m4_c | unmapped_c;
`endif
    idx_c = IDX_W'(0);
    if (hsel_2) idx_c = IDX_W'(1);
    if (hsel_3) idx_c = IDX_W'(2);
    if (hsel_4) idx_c = IDX_W'(3);
  end

  // Data-phase index register; holds through wait states.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sel <= IDX_W'(0);
    end else if (hready) begin
      sel <= idx_c;
    end
  end

`ifdef DEFAULT_SLAVE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } def_state_e;

  def_state_e state, state_nxt;
  logic       rdy_nxt, resp_nxt;
  logic       err_start_c;

  // An accepted NONSEQ/SEQ to an unmapped address starts a two-cycle ERROR.
  assign err_start_c = hready & htrans[1] & unmapped_c;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      def_sel <= 1'b0;
    end else if (hready) begin
      def_sel <= unmapped_c & htrans[1];
    end
  end

  // State and response registers; outputs are registered alongside the state.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state         <= ST_IDLE;
      hreadyout_def <= 1'b1;
      hresp_def     <= 1'b0;
    end else begin
      state         <= state_nxt;
      hreadyout_def <= rdy_nxt;
      hresp_def     <= resp_nxt;
    end
  end

  // Next state and the response values that state will present.
  always_comb begin
    state_nxt = ST_IDLE;
    rdy_nxt   = 1'b1;
    resp_nxt  = 1'b0;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (err_start_c) begin
          state_nxt = ST_ERR1;
          rdy_nxt   = 1'b0;
          resp_nxt  = 1'b1;
        end
      end
      ST_ERR1: begin
        state_nxt = ST_ERR2;
        resp_nxt  = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
`else
  assign def_sel       = 1'b0;
  assign hreadyout_def = 1'b1;
  assign hresp_def     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_decoder.sv
module tb_ahb_decoder;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;
  logic        hsel_1, hsel_2, hsel_3, hsel_4;
  logic [1:0]  sel;
  logic        def_sel, hreadyout_def, hresp_def;

  ahb_decoder dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans), .hready(hready),
    .hsel_1(hsel_1), .hsel_2(hsel_2), .hsel_3(hsel_3), .hsel_4(hsel_4),
    .sel(sel), .def_sel(def_sel), .hreadyout_def(hreadyout_def), .hresp_def(hresp_def)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic [3:0]  hsel;   // {hsel_4, hsel_3, hsel_2, hsel_1}
    logic [1:0]  sel;
    logic        def_sel;
    logic        rdy;
    logic        resp;
  } vec_t;

  typedef struct {
    int         idx;
    logic [1:0] sel;
    logic       def_sel;
    logic       rdy;
    logic       resp;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [1:0] t, input logic r,
                     input logic [3:0] hs, input logic [1:0] s, input logic d,
                     input logic ro, input logic rs);
    vec_t v;
    v.haddr = a; v.htrans = t; v.hready = r; v.hsel = hs;
    v.sel = s; v.def_sel = d; v.rdy = ro; v.resp = rs;
    vecs.push_back(v);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " sel"}, 32'(sel), 32'(0));
    check({tag, " def_sel"}, 32'(def_sel), 32'(0));
    check({tag, " hreadyout_def"}, 32'(hreadyout_def), 32'(1));
    check({tag, " hresp_def"}, 32'(hresp_def), 32'(0));
  endtask

  initial begin
    exp_t e;
    exp_t got;

    // Mapped sequence and wait-state hold (valid in both builds).
    add(32'h1000_0004, 2'b10, 1'b1, 4'b0010, 2'b01, 1'b0, 1'b1, 1'b0);
    add(32'h3000_0000, 2'b10, 1'b1, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0);
    add(32'h2000_0000, 2'b10, 1'b1, 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
    add(32'h0000_0000, 2'b10, 1'b0, 4'b0001, 2'b10, 1'b0, 1'b1, 1'b0);
    add(32'h0000_0000, 2'b10, 1'b0, 4'b0001, 2'b10, 1'b0, 1'b1, 1'b0);
    add(32'h0000_0000, 2'b10, 1'b0, 4'b0001, 2'b10, 1'b0, 1'b1, 1'b0);
    add(32'h0000_0000, 2'b10, 1'b1, 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
`ifdef DEFAULT_SLAVE_EN
    // Single error, back-to-back error, then IDLE/BUSY to unmapped get OKAY.
    add(32'h8000_0000, 2'b10, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1);
    add(32'h8000_0000, 2'b10, 1'b0, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);
    add(32'h8000_0000, 2'b10, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1);
    add(32'h8000_0000, 2'b10, 1'b0, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);
    add(32'h8000_0000, 2'b00, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    add(32'h8000_0000, 2'b00, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    add(32'h9000_0000, 2'b01, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    add(32'h2000_0000, 2'b10, 1'b1, 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
    add(32'h8000_0000, 2'b11, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1);
    add(32'h0000_0000, 2'b00, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b1, 1'b1);
    add(32'h0000_0000, 2'b00, 1'b1, 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
`else
    // Unmapped falls through to slave 4 regardless of htrans.
    add(32'hF000_0000, 2'b10, 1'b1, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0);
    add(32'h8000_0000, 2'b00, 1'b1, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0);
    add(32'h1FFF_FFFF, 2'b10, 1'b1, 4'b0010, 2'b01, 1'b0, 1'b1, 1'b0);
    add(32'h4000_0004, 2'b11, 1'b1, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0);
    add(32'h0000_0000, 2'b10, 1'b1, 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
`endif

    // Asynchronous reset before any clock edge.
    hresetn = 1'b1;
    haddr   = 32'h0;
    htrans  = 2'b00;
    hready  = 1'b1;
    #3 hresetn = 1'b0;
    #1 check_reset_vals("reset");
    @(negedge hclk);
    hresetn = 1'b1;

    // Table: drive at negedge, check decode, scoreboard the registered outputs.
    for (int i = 0; i < vecs.size(); i++) begin
      haddr  = vecs[i].haddr;
      htrans = vecs[i].htrans;
      hready = vecs[i].hready;
      #1;
      check($sformatf("v%0d hsel", i), 32'({hsel_4, hsel_3, hsel_2, hsel_1}), 32'(vecs[i].hsel));
      e.idx = i; e.sel = vecs[i].sel; e.def_sel = vecs[i].def_sel;
      e.rdy = vecs[i].rdy; e.resp = vecs[i].resp;
      exp_q.push_back(e);
      @(posedge hclk);
      #1;
      if (exp_q.size() == 0) begin
        check($sformatf("v%0d scoreboard empty", i), 32'(0), 32'(1));
      end else begin
        got = exp_q.pop_front();
        check($sformatf("v%0d sel", got.idx), 32'(sel), 32'(got.sel));
        check($sformatf("v%0d def_sel", got.idx), 32'(def_sel), 32'(got.def_sel));
        check($sformatf("v%0d hreadyout_def", got.idx), 32'(hreadyout_def), 32'(got.rdy));
        check($sformatf("v%0d hresp_def", got.idx), 32'(hresp_def), 32'(got.resp));
      end
      @(negedge hclk);
    end

    // Mid-transfer asynchronous reset.
    haddr = 32'h2000_0000; htrans = 2'b10; hready = 1'b1;
    @(posedge hclk); #1;
    check("pre-reset sel", 32'(sel), 32'(2'b10));
`ifdef DEFAULT_SLAVE_EN
    @(negedge hclk);
    haddr = 32'h8000_0000; htrans = 2'b10; hready = 1'b1;
    @(posedge hclk); #1;
    check("pre-reset def_sel", 32'(def_sel), 32'(1));
    check("pre-reset hreadyout_def", 32'(hreadyout_def), 32'(0));
`endif
    #2 hresetn = 1'b0;
    #1 check_reset_vals("mid reset");
    @(negedge hclk);
    hresetn = 1'b1;
    haddr = 32'h3000_0000; htrans = 2'b10; hready = 1'b1;
    @(posedge hclk); #1;
    check("post-reset sel", 32'(sel), 32'(2'b11));

    check("scoreboard drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
